// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mult_pkg;

  // Default operand width; the product is twice this wide.
  localparam int DEFAULT_WIDTH = 32;

  // Iteration counter width for the default operand width.
  localparam int COUNT_W = $clog2(DEFAULT_WIDTH);

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter width for an arbitrary operand width, never narrower than one bit.
  function automatic int count_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: add the multiplicand into the upper half of the
// work register when its lsb is set, then shift the whole register right.
module mult_step
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH:0]   p,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH:0]   p_next
);

  logic [WIDTH:0]   upper_sum;
  logic [2*WIDTH:0] added;

  // The carry bit p[2W] is always zero entering an iteration (it was shifted
  // down on the previous step), so adding over p[2W:W] equals adding over
  // p[2W-1:W] with the carry landing in bit 2W.
  always_comb begin
    upper_sum = p[2*WIDTH:WIDTH] + {1'b0, mcand};
    added     = p[0] ? {upper_sum, p[WIDTH-1:0]} : p;
    p_next    = added >> 1;
  end

endmodule

// File: rtl/mult32_seq.sv
// Sequential unsigned multiplier: one shift-add iteration per cycle, a
// one-cycle done strobe and a registered product held until the next result.
module mult32_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = count_width(WIDTH);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  state_t            state;
  logic [CW-1:0]     count;
  logic [WIDTH-1:0]  mcand;
  logic [2*WIDTH:0]  p;
  logic [2*WIDTH:0]  p_next;

  mult_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .p      (p),
    .mcand  (mcand),
    .p_next (p_next)
  );

  // Controller, datapath registers and registered busy/done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= '0;
      mcand   <= '0;
      p       <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a;
            p     <= {{(WIDTH + 1){1'b0}}, b};
            count <= '0;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          p     <= p_next;
          count <= count + 1'b1;
          if (count == LAST_COUNT) begin
            product <= p_next[2*WIDTH-1:0];
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult32_seq.sv
// Self-checking bench for mult32_seq: directed vector table, randomized
// operands against an arithmetic reference, and multi-cycle corner sequences.
module tb_mult32_seq;

  localparam int W = 32;
  localparam int TIMEOUT = W + 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] expected;
  } vec_t;

  vec_t vecs[8];

  mult32_seq #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Global watchdog so the run can never hang.
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: exact unsigned product by plain arithmetic.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] xx;
    logic [2*W-1:0] yy;
    xx = {{W{1'b0}}, x};
    yy = {{W{1'b0}}, y};
    return xx * yy;
  endfunction

  // One comparison: count it and report a mismatch.
  task automatic checkOutput(input string name, input logic [2*W-1:0] actual,
                             input logic [2*W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Present operands with a single-cycle start pulse; returns at the
  // sample point just after the accepting edge.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done, recording cycles since acceptance and busy.
  task automatic waitDone(output int k, output logic busy_ok);
    k = 0;
    busy_ok = 1'b1;
    while (!done && k <= TIMEOUT) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      k++;
    end
  endtask

  // Full operation with latency, busy, product and strobe-width checks.
  task automatic runAndCheck(input string name, input logic [W-1:0] av,
                             input logic [W-1:0] bv, input logic [2*W-1:0] exp);
    int k;
    logic busy_ok;
    applyStimulus(av, bv);
    waitDone(k, busy_ok);
    checkOutput({name, "_latency"}, 64'(k), 64'(W));
    checkOutput({name, "_busy"}, 64'(busy_ok), 64'd1);
    checkOutput({name, "_product"}, product, exp);
    checkOutput({name, "_busy_at_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput({name, "_done_one_cycle"}, 64'(done), 64'd0);
    checkOutput({name, "_product_held"}, product, exp);
  endtask

  initial begin
    int k;
    int ndone;
    logic busy_ok;
    logic held_ok;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{a: 32'd3,          b: 32'd5,          expected: 64'd15};
    vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   expected: 64'hFFFFFFFE_00000001};
    vecs[2] = '{a: 32'd0,          b: 32'h12345678,   expected: 64'd0};
    vecs[3] = '{a: 32'd1,          b: 32'hFFFFFFFF,   expected: 64'h00000000_FFFFFFFF};
    vecs[4] = '{a: 32'h80000000,   b: 32'd2,          expected: 64'h00000001_00000000};
    vecs[5] = '{a: 32'h00010000,   b: 32'h00010000,   expected: 64'h00000001_00000000};
    vecs[6] = '{a: 32'hFFFFFFFF,   b: 32'd2,          expected: 64'h00000001_FFFFFFFE};
    vecs[7] = '{a: 32'h12345678,   b: 32'd0,          expected: 64'd0};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_product", product, 64'd0);
    rst = 1'b0;

    $display("[TB] directed vectors");
    for (int i = 0; i < 8; i++) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].expected);
    end

    $display("[TB] randomized operands");
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) ra = ra >> $urandom_range(31, 0);
      runAndCheck($sformatf("rand%0d", i), ra, rb, model(ra, rb));
    end

    $display("[TB] start held through RUN");
    @(negedge clk);
    a = 32'd7;
    b = 32'd6;
    start = 1'b1;
    @(negedge clk);
    a = 32'd1;
    b = 32'd1;
    waitDone(k, busy_ok);
    start = 1'b0;
    checkOutput("hold_start_latency", 64'(k), 64'(W));
    checkOutput("hold_start_product", product, 64'd42);
    ndone = 0;
    held_ok = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) held_ok = 1'b0;
    end
    checkOutput("hold_start_extra_done", 64'(ndone), 64'd0);
    checkOutput("hold_start_no_restart", 64'(held_ok), 64'd1);

    $display("[TB] reset during RUN");
    applyStimulus(32'd9, 32'd9);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_product", product, 64'd0);
    ndone = 0;
    for (int i = 0; i < W + 4; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", 64'(ndone), 64'd0);
    runAndCheck("after_abort", 32'd2, 32'd4, 64'd8);

    $display("[TB] reset and start on the same edge");
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    a = 32'd5;
    b = 32'd5;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    checkOutput("rst_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput("rst_start_busy_later", 64'(busy), 64'd0);
    checkOutput("rst_start_product", product, 64'd0);

    $display("[TB] product held through next run");
    runAndCheck("hold_first", 32'd3, 32'd5, 64'd15);
    applyStimulus(32'd100, 32'd100);
    k = 0;
    held_ok = 1'b1;
    while (!done && k <= TIMEOUT) begin
      if (product !== 64'd15) held_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    checkOutput("hold_prev_product", 64'(held_ok), 64'd1);
    checkOutput("hold_second_latency", 64'(k), 64'(W));
    checkOutput("hold_second_product", product, 64'd10000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult32_seq.md
# mult32_seq

Sequential unsigned shift-add multiplier that computes a 2*WIDTH-bit product over WIDTH iterations. It sits directly upstream of the 32-bit load-enable result registers. `done` is a single-cycle strobe wired to their `en`, and `product` feeds their data inputs. It replaces a combinational multiplier so that the datapath meets a single-cycle clock budget.

## Interface
- `WIDTH`, default 32: operand width; product width is 2*WIDTH.
- `clk`  in  1  rising-edge clock; the block uses one clock.
- `rst`  in  1  reset; synchronous, active-high; has priority over all other inputs.
- `start`  in  1  request to multiply; honoured only in IDLE.
- `a`  in  WIDTH  multiplicand; sampled on the edge that accepts `start`.
- `b`  in  WIDTH  multiplier; sampled on the edge that accepts `start`.
- `busy`  out  1  high in RUN.
- `done`  out  1  high for exactly one cycle (DONE state); drives downstream `en`.
- `product`  out  2*WIDTH  registered result; changes only on the completion edge.

## Operation
- States are IDLE, RUN and DONE. The FSM resets to IDLE.
- IDLE:
  - If `start`=1 at an edge, latch `a` into the multiplicand register.
  - Load the work register P (2*WIDTH+1 bits, including carry) with {0, b}.
  - Set count=0 and go to RUN.
- RUN, one iteration per cycle:
  - If P[0]=1, then P[2W:W] = P[2W-1:W] + mcand, with carry into bit 2W.
  - Then shift P right by 1 and set count = count+1.
  - When count reaches WIDTH-1 on this edge (the WIDTH-th iteration), load `product` with the final P[2W-1:0] and go to DONE.
- DONE: `done`=1 for one cycle, then unconditionally return to IDLE.
- `start` in RUN or DONE is ignored. It is not queued; the requester must re-assert `start` in IDLE.
- Arithmetic is unsigned only and the result is exact. The carry bit prevents overflow, and the product never wraps.
- `product` holds the last result through subsequent IDLE and RUN periods until the next completion edge.
- Reset mid-operation:
  - The next edge with `rst`=1 forces IDLE and clears count, P, the multiplicand and `product` to 0.
  - `busy` and `done` go to 0. No `done` pulse is emitted for the aborted operation.
- Reset values: `busy`=0, `done`=0, `product`=0.

## Timing
- Let edge N be the edge at which `start` is accepted.
- `busy`=1 from after edge N through edge N+WIDTH.
- `product` is valid and `done`=1 in the cycle after edge N+WIDTH. That is cycle N+33 for WIDTH=32.
- Latency from `start` to `done` is WIDTH+1 cycles.
- The earliest next accepted `start` is edge N+WIDTH+2. The throughput is one product per WIDTH+2 cycles.
- `done` and `product` come from registers, with no combinational path from inputs to outputs. A downstream register with `en`=`done` captures `product` on edge N+WIDTH+1.
- When `rst` and `start` are asserted on the same edge, reset wins.

## Structure
- Shared package `mult_pkg`:
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - default WIDTH constant;
  - count width, computed as clog2(WIDTH).
- Sub-module `mult_step`: purely combinational single iteration (conditional add plus right shift), taking P and the multiplicand and returning the next P.
- The top level holds the FSM, the counter, the operand, P and `product` registers.

## Test plan
- Reset, then `a`=3, `b`=5, `start` pulse. Required: `busy` for 32 cycles, then `done` high for one cycle, and `product`=64'd15 at edge N+33.
- `a`=`b`=32'hFFFFFFFF. Required: `product`=64'hFFFFFFFE_00000001, with no wrap.
- `a`=0, `b`=32'h12345678. Required: `product`=0, with `done` still at exactly N+33.
- Hold `start` high during RUN after `a`=7, `b`=6 is accepted. Required: exactly one `done`, `product`=42. A new operation starts only once the block is back in IDLE.
- Start `a`=9, `b`=9, then assert `rst` at cycle 10 of RUN. Required: next cycle `busy`=0, `product`=0, and no `done` pulse. A following 2x4 run gives 8.
- Run 3x5 and check that `product`=15 is held through the next 100x100 run until its completion edge, which gives 10000.
